// File: rtl/reg_file_2rp_if.sv
// ---------------------------------------------------------------------------
// reg_file_2rp_if
// Bus bundle for the two-read-port register file.
//   master : drives clear, both read requests and the write request;
//            observes read data and the per-entry flag vectors.
//   slave  : the register file itself (mirror of master).
// Signals:
//   clear                    synchronous clear of all entries
//   read_en_x / read_addr_x  read request, port x (x = 0, 1)
//   read_data_x              registered read data, port x
//   write_en / write_addr / write_data  write request
//   zeros                    bit i set when entry i == 0
//   g_zeros                  bit i set when entry i > 0 (signed)
// ---------------------------------------------------------------------------
interface reg_file_2rp_if #(
    parameter int BIT_WIDTH = 16,
    parameter int REG_DEPTH = 16
);
    localparam int ADDR_WIDTH = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic                  clear;
    logic                  read_en_0;
    logic [ADDR_WIDTH-1:0] read_addr_0;
    logic [BIT_WIDTH-1:0]  read_data_0;
    logic                  read_en_1;
    logic [ADDR_WIDTH-1:0] read_addr_1;
    logic [BIT_WIDTH-1:0]  read_data_1;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [BIT_WIDTH-1:0]  write_data;
    logic [REG_DEPTH-1:0]  zeros;
    logic [REG_DEPTH-1:0]  g_zeros;

    modport master (
        output clear,
        output read_en_0, read_addr_0,
        output read_en_1, read_addr_1,
        output write_en, write_addr, write_data,
        input  read_data_0, read_data_1,
        input  zeros, g_zeros
    );

    modport slave (
        input  clear,
        input  read_en_0, read_addr_0,
        input  read_en_1, read_addr_1,
        input  write_en, write_addr, write_data,
        output read_data_0, read_data_1,
        output zeros, g_zeros
    );
endinterface

// File: rtl/reg_file_2rp.sv
// ---------------------------------------------------------------------------
// reg_file_2rp
// Flip-flop register file with two independent registered read ports, one
// write port and a synchronous whole-array clear. Entries are two's-complement
// signed; per-entry zero / strictly-positive flags are produced
// combinationally from the array for zero-skipping and ReLU-style sparsity.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (array and read data to zero)
//   bus    reg_file_2rp_if slave modport (see interface for signal list)
// Reads sample the pre-edge array, so a read coincident with a write or a
// clear to the same entry returns the old value. Clear beats write.
// Out-of-range addresses (non power-of-two depth) drop writes and read zero.
// ---------------------------------------------------------------------------
module reg_file_2rp #(
    parameter int BIT_WIDTH = 16,
    parameter int REG_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_file_2rp_if.slave       bus
);
    localparam int ADDR_WIDTH = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    // Depth expressed one bit wider than an address so the range check
    // cannot overflow when REG_DEPTH is an exact power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(REG_DEPTH);

    logic [BIT_WIDTH-1:0] mem_q [REG_DEPTH];
    logic [BIT_WIDTH-1:0] mem_d [REG_DEPTH];
    logic [BIT_WIDTH-1:0] rd0_q;
    logic [BIT_WIDTH-1:0] rd0_d;
    logic [BIT_WIDTH-1:0] rd1_q;
    logic [BIT_WIDTH-1:0] rd1_d;
    logic [REG_DEPTH-1:0] zeros_s;
    logic [REG_DEPTH-1:0] g_zeros_s;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // Array next state: clear wins over write; out-of-range writes are dropped.
    always_comb begin
        for (int i = 0; i < REG_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.clear) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_d[i] = {BIT_WIDTH{1'b0}};
            end
        end else if (bus.write_en && addr_ok(bus.write_addr)) begin
            mem_d[bus.write_addr] = bus.write_data;
        end else begin
            mem_d[0] = mem_q[0];
        end
    end

    // Read port next state: load from the pre-edge array or hold.
    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (bus.read_en_0) begin
            if (addr_ok(bus.read_addr_0)) begin
                rd0_d = mem_q[bus.read_addr_0];
            end else begin
                rd0_d = {BIT_WIDTH{1'b0}};
            end
        end else begin
            rd0_d = rd0_q;
        end
        if (bus.read_en_1) begin
            if (addr_ok(bus.read_addr_1)) begin
                rd1_d = mem_q[bus.read_addr_1];
            end else begin
                rd1_d = {BIT_WIDTH{1'b0}};
            end
        end else begin
            rd1_d = rd1_q;
        end
    end

    // Per-entry flags straight from the array, no extra latency after a write.
    always_comb begin
        zeros_s   = {REG_DEPTH{1'b0}};
        g_zeros_s = {REG_DEPTH{1'b0}};
        for (int i = 0; i < REG_DEPTH; i++) begin
            zeros_s[i]   = (mem_q[i] == {BIT_WIDTH{1'b0}});
            g_zeros_s[i] = (mem_q[i][BIT_WIDTH-1] == 1'b0) &&
                           (mem_q[i] != {BIT_WIDTH{1'b0}});
        end
    end

    // State registers: array and read data, asynchronously reset to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_q[i] <= {BIT_WIDTH{1'b0}};
            end
            rd0_q <= {BIT_WIDTH{1'b0}};
            rd1_q <= {BIT_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd0_q <= rd0_d;
            rd1_q <= rd1_d;
        end
    end

    assign bus.read_data_0 = rd0_q;
    assign bus.read_data_1 = rd1_q;
    assign bus.zeros       = zeros_s;
    assign bus.g_zeros     = g_zeros_s;

endmodule

// File: tb/tb_reg_file_2rp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2rp
// Directed bench for reg_file_2rp. A reference array tracks the expected
// contents; read results are queued when a read is issued and popped after
// the clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_reg_file_2rp;
    localparam int BW = 16;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;

    reg_file_2rp_if #(.BIT_WIDTH(BW), .REG_DEPTH(DEPTH)) bus ();

    reg_file_2rp #(.BIT_WIDTH(BW), .REG_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [BW-1:0] model [DEPTH];
    logic [BW-1:0] q0 [$];
    logic [BW-1:0] q1 [$];
    logic [BW-1:0] exp_rd0;
    logic [BW-1:0] exp_rd1;

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH-1:0] exp_zeros();
        logic [DEPTH-1:0] z;
        z = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) z[i] = (model[i] == 16'h0000);
        return z;
    endfunction

    function automatic logic [DEPTH-1:0] exp_gz();
        logic [DEPTH-1:0] g;
        g = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) g[i] = !model[i][BW-1] && (model[i] != 16'h0000);
        return g;
    endfunction

    task automatic idle();
        bus.clear     = 1'b0;
        bus.read_en_0 = 1'b0;
        bus.read_en_1 = 1'b0;
        bus.write_en  = 1'b0;
    endtask

    // One clock: predict, advance, compare everything, then drop requests.
    task automatic tick();
        if (bus.read_en_0) q0.push_back(model[bus.read_addr_0]);
        if (bus.read_en_1) q1.push_back(model[bus.read_addr_1]);
        if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        end else if (bus.write_en) begin
            model[bus.write_addr] = bus.write_data;
        end
        @(posedge clk);
        #1;
        if (q0.size() > 0) exp_rd0 = q0.pop_front();
        if (q1.size() > 0) exp_rd1 = q1.pop_front();
        chk("rd0", bus.read_data_0, exp_rd0);
        chk("rd1", bus.read_data_1, exp_rd1);
        chk("zeros", bus.zeros, exp_zeros());
        chk("g_zeros", bus.g_zeros, exp_gz());
        idle();
    endtask

    task automatic wr(input logic [3:0] a, input logic [BW-1:0] d);
        bus.write_en   = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
        q0.delete();
        q1.delete();
        exp_rd0 = 16'h0000;
        exp_rd1 = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.read_addr_0 = 4'd0;
        bus.read_addr_1 = 4'd0;
        bus.write_addr  = 4'd0;
        bus.write_data  = 16'h0000;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd0", bus.read_data_0, 16'h0000);
        chk("reset_rd1", bus.read_data_1, 16'h0000);
        chk("reset_zeros", bus.zeros, 16'hFFFF);
        chk("reset_gz", bus.g_zeros, 16'h0000);
        rst_n = 1'b1;

        // Basic writes and flags
        wr(4'd3, 16'd5);    tick();
        wr(4'd7, 16'hFFFE); tick();
        wr(4'd0, 16'h0000); tick();
        chk("flags_zeros", bus.zeros, 16'hFF77);
        chk("flags_gz", bus.g_zeros, 16'h0008);

        // Dual read, then hold with enables low
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd3;
        bus.read_en_1 = 1'b1; bus.read_addr_1 = 4'd7;
        tick();
        chk("dual_rd0", bus.read_data_0, 16'd5);
        chk("dual_rd1", bus.read_data_1, 16'hFFFE);
        bus.read_addr_0 = 4'd0; bus.read_addr_1 = 4'd1;
        tick();
        chk("hold_rd0", bus.read_data_0, 16'd5);
        chk("hold_rd1", bus.read_data_1, 16'hFFFE);

        // Read-during-write, port 0
        wr(4'd4, 16'd10); tick();
        wr(4'd4, 16'd20); bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd4; tick();
        chk("rdw0_old", bus.read_data_0, 16'd10);
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd4; tick();
        chk("rdw0_new", bus.read_data_0, 16'd20);

        // Read-during-write, port 1
        wr(4'd4, 16'd10); tick();
        wr(4'd4, 16'd20); bus.read_en_1 = 1'b1; bus.read_addr_1 = 4'd4; tick();
        chk("rdw1_old", bus.read_data_1, 16'd10);
        bus.read_en_1 = 1'b1; bus.read_addr_1 = 4'd4; tick();
        chk("rdw1_new", bus.read_data_1, 16'd20);

        // Clear beats write; coincident read sees pre-clear data
        bus.clear = 1'b1;
        wr(4'd2, 16'd9);
        bus.read_en_1 = 1'b1; bus.read_addr_1 = 4'd3;
        tick();
        chk("clr_rd1", bus.read_data_1, 16'd5);
        chk("clr_zeros", bus.zeros, 16'hFFFF);
        chk("clr_gz", bus.g_zeros, 16'h0000);
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd2; tick();
        chk("clr_rd_addr2", bus.read_data_0, 16'h0000);

        // Boundary values and last address
        wr(4'd5, 16'h7FFF); tick();
        chk("max_pos_gz", bus.g_zeros, 16'h0020);
        chk("max_pos_zeros", bus.zeros, 16'hFFDF);
        wr(4'd6, 16'h8000); tick();
        chk("min_neg_gz", bus.g_zeros, 16'h0020);
        chk("min_neg_zeros", bus.zeros, 16'hFF9F);
        wr(4'd15, 16'h1234); tick();
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd15;
        bus.read_en_1 = 1'b1; bus.read_addr_1 = 4'd15;
        tick();
        chk("last_rd0", bus.read_data_0, 16'h1234);
        chk("last_rd1", bus.read_data_1, 16'h1234);

        // Asynchronous reset between edges; writes during reset are ignored
        #2;
        wr(4'd9, 16'h0055);
        rst_n = 1'b0;
        #1;
        chk("arst_rd0", bus.read_data_0, 16'h0000);
        chk("arst_rd1", bus.read_data_1, 16'h0000);
        chk("arst_zeros", bus.zeros, 16'hFFFF);
        chk("arst_gz", bus.g_zeros, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("inrst_zeros", bus.zeros, 16'hFFFF);
        idle();
        rst_n = 1'b1;
        reset_model();
        tick();
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd9; tick();
        chk("post_rst_rd9", bus.read_data_0, 16'h0000);

        // Sanity after reset recovery
        wr(4'd1, 16'd3); tick();
        bus.read_en_0 = 1'b1; bus.read_addr_0 = 4'd1; tick();
        chk("post_rst_rd1", bus.read_data_0, 16'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_2rp.md
Name: reg_file_2rp

Overview:
- Small flip-flop register file: two independent read ports, one write port, synchronous whole-array clear.
- Per-entry zero and greater-than-zero (signed) flag vectors.
- Used in pairs inside each processing element as ping-pong input/output activation storage.
- Flags feed zero-skipping and ReLU-style sparsity logic.

Parameters:
- BIT_WIDTH, 16, width of each entry; entries are two's-complement signed.
- REG_DEPTH, 16, number of entries.
- ADDR_WIDTH (localparam), ceil(log2(REG_DEPTH)), minimum 1; width of all address ports.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all entries.
- read_en_0  input  1  read enable, port 0.
- read_addr_0  input  ADDR_WIDTH  read address, port 0.
- read_data_0  output  BIT_WIDTH  registered read data, port 0.
- read_en_1  input  1  read enable, port 1.
- read_addr_1  input  ADDR_WIDTH  read address, port 1.
- read_data_1  output  BIT_WIDTH  registered read data, port 1.
- write_en  input  1  write enable.
- write_addr  input  ADDR_WIDTH  write address.
- write_data  input  BIT_WIDTH  write data.
- zeros  output  REG_DEPTH  bit i = 1 when entry i == 0.
- g_zeros  output  REG_DEPTH  bit i = 1 when entry i > 0 (signed).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries cleared to 0.
  - read_data_0 and read_data_1 forced to 0.
  - Consequently zeros = all ones, g_zeros = all zeros.
- Write: on a rising edge with write_en=1 and clear=0, entry[write_addr] <= write_data. The new value is visible to flags and reads from the next cycle.
- Clear:
  - On a rising edge with clear=1, every entry becomes 0.
  - Clear has priority over a simultaneous write; the write is discarded.
  - Read data registers are not affected by clear.
- Read ports (ports 0 and 1 are fully independent and identical):
  - On a rising edge with read_en_x=1, read_data_x <= entry[read_addr_x], using the pre-edge array contents. Latency is 1 cycle.
  - With read_en_x=0, read_data_x holds its previous value.
- Read-during-write, same address: the read returns the OLD value; the new value is visible on a read issued one cycle later. Same rule for read coincident with clear (returns the pre-clear value).
- Both read ports may target the same address, or the write address, in the same cycle without conflict.
- Out-of-range address (only possible when REG_DEPTH is not a power of 2):
  - Write is ignored.
  - Read loads 0.
- Flags:
  - Purely combinational from current array contents; no added latency after the write edge.
  - zeros[i] = (entry[i] == 0).
  - g_zeros[i] = (entry[i][BIT_WIDTH-1] == 0) && (entry[i] != 0).
  - Most negative value (MSB=1, rest 0): zeros=0, g_zeros=0.
- No X propagation: all state is reset; outputs are defined at all times after reset.

Test Plan:
- Reset, then write entry 3=5, entry 7=-2, entry 0=0 → next cycle:
  - zeros bit3=0, bit7=0, all others=1.
  - g_zeros only bit3=1.
- Read ports: port0 reads addr 3 and port1 reads addr 7 in the same cycle → after one edge read_data_0=5, read_data_1=16'hFFFE. Then drop both enables and change addresses → outputs hold 5 / FFFE.
- Read-during-write: entry 4=10, then write 4=20 while port0 reads 4 → read_data_0=10. Read again next cycle → 20. Repeat with port1 → same results.
- Clear priority: clear=1 with write_en=1 to addr 2=9, port1 reading addr 3 (value 5) →
  - read_data_1=5 (pre-clear value).
  - Afterwards all entries 0, zeros all ones, g_zeros all zeros.
  - Read addr 2 → 0.
- Boundary values:
  - Write 16'h7FFF → g_zeros=1, zeros=0.
  - Write 16'h8000 → g_zeros=0, zeros=0.
  - Write to last address REG_DEPTH-1 → readable on both ports.
- Asynchronous reset mid-operation: assert rst_n low between clock edges after data is loaded → read_data_0/1 go 0 and zeros go all ones immediately, without waiting for a clock edge. Writes presented while in reset are ignored.
